bus_arbiter_n: RTL and testbench
================================

BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

Interface
REQ-001 Parameter NM, default 4: number of masters; legal range 2..16.
REQ-002 Parameter AW, default 48: address width.
REQ-003 Parameter DW, default 16: data width.
REQ-004 Parameter RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with the lowest index winning.
REQ-005 Parameter TMO, default 255: the maximum number of cycles to wait for slave Xend; legal range 1..65535.
REQ-006 Port Qclock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port BusReset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port request, input, NM bits: the per-master bus request.
REQ-009 Port itsyours, output, NM bits: the per-master grant, one-hot or zero.
REQ-010 Port QmAddr, input, NM*AW bits: the master addresses, with master i at bits [i*AW +: AW].
REQ-011 Port mdout, input, NM*DW bits: the master write data, with master i at bits [i*DW +: DW].
REQ-012 Port Mdin, output, DW bits: the read data returned to masters, broadcast to all.
REQ-013 Port Xend_mstr, output, NM bits: the per-master end-of-transfer pulse.
REQ-014 Port bus_err, output, 1 bit: the timeout flag, qualified by Xend_mstr.
REQ-015 Port Adr, output, AW bits: the slave address.
REQ-016 Port dataIn, output, DW bits: the slave write data.
REQ-017 Port select_slave, output, 1 bit: the slave select.
REQ-018 Port dbus_out, input, DW bits: the slave read data.
REQ-019 Port Xend, input, 1 bit: the slave transfer complete.

Function
REQ-020 The FSM SHALL have states IDLE, GRANT and XFER; the encoding is free.
REQ-021 In IDLE with request != 0, the arbiter SHALL register the winner index w, set itsyours[w]=1 and enter GRANT on the same edge.
REQ-022 When RR=1, the search SHALL start at (last_winner+1) mod NM and wrap; last_winner SHALL update only when a grant is issued.
REQ-023 When RR=0, the arbiter SHALL choose the lowest set index of request.
REQ-024 In GRANT, the next edge SHALL latch Adr<=QmAddr[w], latch dataIn<=mdout[w], set select_slave=1, clear the timeout counter and enter XFER.
REQ-025 In XFER with Xend=1, the edge SHALL latch Mdin<=dbus_out, set Xend_mstr[w]=1, clear itsyours and select_slave, keep bus_err=0 and enter IDLE.
REQ-026 In XFER with Xend=0, the timeout counter SHALL increment; on the edge where it equals TMO, XFER SHALL end as in REQ-025 except Mdin is left unchanged and bus_err=1.
REQ-027 Xend_mstr and bus_err SHALL be single-cycle pulses, cleared on the next edge.
REQ-028 IDLE MAY grant in the same cycle that Xend_mstr is high, so the minimum request-to-request turnaround is 3 cycles (grant, transfer, completion).
REQ-029 Deassertion of request[w] during GRANT or XFER SHALL be ignored; the transfer completes or times out normally.
REQ-030 Changes on request for non-granted masters SHALL NOT affect the current transfer.
REQ-031 Xend while in IDLE or GRANT SHALL be ignored.
REQ-032 Adr and dataIn SHALL hold their values outside GRANT-to-XFER latching; no combinational path from any input to any output is permitted.
REQ-033 The timeout counter SHALL be ceil(log2(TMO+1)) bits wide and SHALL never wrap.
REQ-034 itsyours SHALL be one-hot or zero at all times.

Reset
REQ-035 BusReset=0 SHALL immediately force IDLE and clear itsyours, Xend_mstr, bus_err, select_slave, Adr, dataIn, Mdin and the timeout counter, and set last_winner to NM-1 so that master 0 has first priority.
REQ-036 Reset asserted during XFER SHALL abort the transfer with no Xend_mstr pulse.
REQ-037 Operation SHALL resume on the first rising edge after BusReset returns to 1.

Verification
REQ-038 Single request, NM=4, RR=1: request=0001, QmAddr[0]=0x123456789ABC, mdout[0]=0xBEEF, slave Xend after 2 XFER cycles with dbus_out=0x5A5A -> itsyours=0001 at cycle 1, select_slave=1 with Adr=0x123456789ABC and dataIn=0xBEEF at cycle 2, Mdin=0x5A5A and Xend_mstr=0001 one cycle, bus_err=0.
REQ-039 Round-robin fairness: request=1111 held, slave Xend immediate -> grant order 0,1,2,3,0; each itsyours one-hot.
REQ-040 Fixed priority, RR=0: request=1010 held -> master 1 granted repeatedly and master 3 never.
REQ-041 Timeout, TMO=5: Xend held 0 -> Xend_mstr[w]=1 and bus_err=1 on the 5th XFER-counted edge, Mdin unchanged, FSM returns to IDLE.
REQ-042 Reset mid-XFER: BusReset=0 asynchronously -> all outputs 0 before the next clock edge, no Xend_mstr pulse; after release with request=1000, master 3 is granted and last_winner returns to 3.
REQ-043 Request dropped in XFER plus stray Xend in IDLE: the transfer still completes with one Xend_mstr pulse; the stray Xend produces no output change.

Source files
------------

// File: rtl/bus_arbiter_n_if.sv
// Bus bundle for the N-master arbiter: master-side request/grant/data and single-slave transfer signals.
// The arbiter connects through the master modport; the environment drives it through the slave modport.
interface bus_arbiter_n_if #(
  parameter int NM = 4,
  parameter int AW = 48,
  parameter int DW = 16
);
  logic [NM-1:0]    request;
  logic [NM-1:0]    itsyours;
  logic [NM*AW-1:0] QmAddr;
  logic [NM*DW-1:0] mdout;
  logic [DW-1:0]    Mdin;
  logic [NM-1:0]    Xend_mstr;
  logic             bus_err;
  logic [AW-1:0]    Adr;
  logic [DW-1:0]    dataIn;
  logic             select_slave;
  logic [DW-1:0]    dbus_out;
  logic             Xend;

  modport master (
    input  request, QmAddr, mdout, dbus_out, Xend,
    output itsyours, Mdin, Xend_mstr, bus_err, Adr, dataIn, select_slave
  );

  modport slave (
    output request, QmAddr, mdout, dbus_out, Xend,
    input  itsyours, Mdin, Xend_mstr, bus_err, Adr, dataIn, select_slave
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-master single-slave bus arbiter: round-robin or fixed-priority grant, one transfer at a time,
// with a slave-completion timeout. Every output comes straight from a register.
module bus_arbiter_n #(
  parameter int NM  = 4,
  parameter int AW  = 48,
  parameter int DW  = 16,
  parameter int RR  = 1,
  parameter int TMO = 255
) (
  input logic             Qclock,
  input logic             BusReset,
  bus_arbiter_n_if.master bus
);
  localparam int IW = $clog2(NM);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] w_q, w_d;
  logic [IW-1:0] last_q, last_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [NM-1:0] xm_q, xm_d;
  logic          sel_q, sel_d;
  logic          err_q, err_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] mdin_q, mdin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] win;

  // Round-robin scans upward from the master after the last winner; fixed priority scans from 0.
  function automatic logic [IW-1:0] pick(input logic [NM-1:0] req, input logic [IW-1:0] last);
    logic [IW-1:0] res;
    logic          found;
    int            idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (RR != 0) idx = (int'(last) + 1 + k) % NM;
      else         idx = k;
      if (!found && req[idx]) begin
        res   = IW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb win = pick(bus.request, last_q);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    xm_d    = '0;
    err_d   = 1'b0;
    sel_d   = sel_q;
    adr_d   = adr_q;
    din_d   = din_q;
    mdin_d  = mdin_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.request) begin
          w_d     = win;
          last_d  = win;
          gnt_d   = NM'(1) << win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        adr_d   = bus.QmAddr[int'(w_q)*AW +: AW];
        din_d   = bus.mdout[int'(w_q)*DW +: DW];
        sel_d   = 1'b1;
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        if (bus.Xend) begin
          mdin_d    = bus.dbus_out;
          xm_d[w_q] = 1'b1;
          gnt_d     = '0;
          sel_d     = 1'b0;
          state_d   = IDLE;
        end else begin
          // Counter stops at TMO on the timeout edge, so it never wraps.
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            xm_d[w_q] = 1'b1;
            err_d     = 1'b1;
            gnt_d     = '0;
            sel_d     = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Qclock or negedge BusReset) begin
    if (!BusReset) begin
      state_q <= IDLE;
      w_q     <= '0;
      last_q  <= LAST_RST;
      gnt_q   <= '0;
      xm_q    <= '0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
      mdin_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      xm_q    <= xm_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      mdin_q  <= mdin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.itsyours     = gnt_q;
  assign bus.Xend_mstr    = xm_q;
  assign bus.bus_err      = err_q;
  assign bus.select_slave = sel_q;
  assign bus.Adr          = adr_q;
  assign bus.dataIn       = din_q;
  assign bus.Mdin         = mdin_q;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: a cycle table for single transfers and round-robin order,
// plus hand sequences for timeout, reset mid-transfer, stray Xend and fixed priority.
module tb_bus_arbiter_n;
  localparam int NM = 4;
  localparam int AW = 48;
  localparam int DW = 16;

  localparam logic [AW-1:0] A0 = 48'h1234_5678_9ABC;
  localparam logic [AW-1:0] A1 = 48'hA1A1_0000_0001;
  localparam logic [AW-1:0] A2 = 48'hA2A2_0000_0002;
  localparam logic [AW-1:0] A3 = 48'hA3A3_0000_0003;
  localparam logic [DW-1:0] D0 = 16'hBEEF;
  localparam logic [DW-1:0] D1 = 16'hD111;
  localparam logic [DW-1:0] D2 = 16'hD222;
  localparam logic [DW-1:0] D3 = 16'hD333;

  logic Qclock;
  logic BusReset;
  int   n_chk  = 0;
  int   n_fail = 0;

  bus_arbiter_n_if #(.NM(NM), .AW(AW), .DW(DW)) irr ();
  bus_arbiter_n_if #(.NM(NM), .AW(AW), .DW(DW)) ifp ();

  bus_arbiter_n #(.NM(NM), .AW(AW), .DW(DW), .RR(1), .TMO(5)) dut_rr (
    .Qclock(Qclock), .BusReset(BusReset), .bus(irr)
  );
  bus_arbiter_n #(.NM(NM), .AW(AW), .DW(DW), .RR(0), .TMO(5)) dut_fp (
    .Qclock(Qclock), .BusReset(BusReset), .bus(ifp)
  );

  initial Qclock = 1'b0;
  always #5 Qclock = ~Qclock;

  typedef struct {
    logic          pre_rst;
    logic [3:0]    req;
    logic          xend;
    logic [15:0]   dbus;
    logic [3:0]    gnt;
    logic          sel;
    logic [3:0]    xm;
    logic          err;
    logic [15:0]   mdin;
    logic [47:0]   adr;
    logic [15:0]   din;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic p, input logic [3:0] rq, input logic xe,
                              input logic [15:0] db, input logic [3:0] g, input logic s,
                              input logic [3:0] x, input logic e, input logic [15:0] md,
                              input logic [47:0] ad, input logic [15:0] dn);
    vec_t v;
    v.pre_rst = p;  v.req = rq;  v.xend = xe; v.dbus = db;
    v.gnt = g;      v.sel = s;   v.xm = x;    v.err = e;
    v.mdin = md;    v.adr = ad;  v.din = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Qclock);
    #1;
  endtask

  task automatic do_reset();
    BusReset = 1'b0;
    repeat (2) @(posedge Qclock);
    #2 BusReset = 1'b1;
    #1;
  endtask

  always @(negedge Qclock) begin
    chk("onehot_rr", 64'($onehot0(irr.itsyours)), 64'd1);
    chk("onehot_fp", 64'($onehot0(ifp.itsyours)), 64'd1);
  end

  initial begin
    BusReset     = 1'b1;
    irr.request  = '0;
    irr.Xend     = 1'b0;
    irr.dbus_out = '0;
    irr.QmAddr   = {A3, A2, A1, A0};
    irr.mdout    = {D3, D2, D1, D0};
    ifp.request  = '0;
    ifp.Xend     = 1'b0;
    ifp.dbus_out = '0;
    ifp.QmAddr   = {A3, A2, A1, A0};
    ifp.mdout    = {D3, D2, D1, D0};

    //           rst req     xe dbus      gnt     sel xm      er mdin      adr  din
    tbl[0]  = mk(0, 4'b0001, 0, 16'h0000, 4'b0001, 0, 4'b0000, 0, 16'h0000, '0, '0);
    tbl[1]  = mk(0, 4'b0001, 0, 16'h0000, 4'b0001, 1, 4'b0000, 0, 16'h0000, A0, D0);
    tbl[2]  = mk(0, 4'b0000, 0, 16'h0000, 4'b0001, 1, 4'b0000, 0, 16'h0000, A0, D0);
    tbl[3]  = mk(0, 4'b0000, 1, 16'h5A5A, 4'b0000, 0, 4'b0001, 0, 16'h5A5A, A0, D0);
    tbl[4]  = mk(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 16'h5A5A, A0, D0);
    tbl[5]  = mk(1, 4'b1111, 1, 16'h1111, 4'b0001, 0, 4'b0000, 0, 16'h0000, '0, '0);
    tbl[6]  = mk(0, 4'b1111, 1, 16'h1111, 4'b0001, 1, 4'b0000, 0, 16'h0000, A0, D0);
    tbl[7]  = mk(0, 4'b1111, 1, 16'h1111, 4'b0000, 0, 4'b0001, 0, 16'h1111, A0, D0);
    tbl[8]  = mk(0, 4'b1111, 1, 16'h1111, 4'b0010, 0, 4'b0000, 0, 16'h1111, A0, D0);
    tbl[9]  = mk(0, 4'b1111, 1, 16'h1111, 4'b0010, 1, 4'b0000, 0, 16'h1111, A1, D1);
    tbl[10] = mk(0, 4'b1111, 1, 16'h1111, 4'b0000, 0, 4'b0010, 0, 16'h1111, A1, D1);
    tbl[11] = mk(0, 4'b1111, 1, 16'h1111, 4'b0100, 0, 4'b0000, 0, 16'h1111, A1, D1);
    tbl[12] = mk(0, 4'b1111, 1, 16'h1111, 4'b0100, 1, 4'b0000, 0, 16'h1111, A2, D2);
    tbl[13] = mk(0, 4'b1111, 1, 16'h1111, 4'b0000, 0, 4'b0100, 0, 16'h1111, A2, D2);
    tbl[14] = mk(0, 4'b1111, 1, 16'h1111, 4'b1000, 0, 4'b0000, 0, 16'h1111, A2, D2);
    tbl[15] = mk(0, 4'b1111, 1, 16'h1111, 4'b1000, 1, 4'b0000, 0, 16'h1111, A3, D3);
    tbl[16] = mk(0, 4'b1111, 1, 16'h1111, 4'b0000, 0, 4'b1000, 0, 16'h1111, A3, D3);
    tbl[17] = mk(0, 4'b1111, 1, 16'h1111, 4'b0001, 0, 4'b0000, 0, 16'h1111, A3, D3);
    tbl[18] = mk(0, 4'b1111, 1, 16'h1111, 4'b0001, 1, 4'b0000, 0, 16'h1111, A0, D0);
    tbl[19] = mk(0, 4'b1111, 1, 16'h1111, 4'b0000, 0, 4'b0001, 0, 16'h1111, A0, D0);

    // Asynchronous reset seen before any clock edge
    #1 BusReset = 1'b0;
    #1;
    chk("rst_gnt",  64'(irr.itsyours),     64'd0);
    chk("rst_sel",  64'(irr.select_slave), 64'd0);
    chk("rst_xm",   64'(irr.Xend_mstr),    64'd0);
    chk("rst_err",  64'(irr.bus_err),      64'd0);
    chk("rst_adr",  64'(irr.Adr),          64'd0);
    chk("rst_din",  64'(irr.dataIn),       64'd0);
    chk("rst_mdin", 64'(irr.Mdin),         64'd0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      irr.request  = tbl[i].req;
      irr.Xend     = tbl[i].xend;
      irr.dbus_out = tbl[i].dbus;
      if (tbl[i].pre_rst) do_reset();
      step();
      chk($sformatf("r%0d_gnt", i),  64'(irr.itsyours),     64'(tbl[i].gnt));
      chk($sformatf("r%0d_sel", i),  64'(irr.select_slave), 64'(tbl[i].sel));
      chk($sformatf("r%0d_xm", i),   64'(irr.Xend_mstr),    64'(tbl[i].xm));
      chk($sformatf("r%0d_err", i),  64'(irr.bus_err),      64'(tbl[i].err));
      chk($sformatf("r%0d_mdin", i), 64'(irr.Mdin),         64'(tbl[i].mdin));
      chk($sformatf("r%0d_adr", i),  64'(irr.Adr),          64'(tbl[i].adr));
      chk($sformatf("r%0d_din", i),  64'(irr.dataIn),       64'(tbl[i].din));
    end

    // Timeout with own request dropped and others toggling mid-transfer
    irr.request  = 4'b0100;
    irr.Xend     = 1'b0;
    irr.dbus_out = 16'hFFFF;
    step();
    chk("to_gnt", 64'(irr.itsyours), 64'h4);
    step();
    chk("to_sel", 64'(irr.select_slave), 64'd1);
    chk("to_adr", 64'(irr.Adr), 64'(A2));
    irr.request = 4'b1011;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 5) begin
        chk($sformatf("to_wait%0d_xm", k),  64'(irr.Xend_mstr),    64'd0);
        chk($sformatf("to_wait%0d_sel", k), 64'(irr.select_slave), 64'd1);
        chk($sformatf("to_wait%0d_gnt", k), 64'(irr.itsyours),     64'h4);
      end else begin
        chk("to_xm",   64'(irr.Xend_mstr),    64'h4);
        chk("to_err",  64'(irr.bus_err),      64'd1);
        chk("to_sel0", 64'(irr.select_slave), 64'd0);
        chk("to_gnt0", 64'(irr.itsyours),     64'd0);
        chk("to_mdin", 64'(irr.Mdin),         64'h1111);
      end
    end
    step();
    chk("to_xm_clr",  64'(irr.Xend_mstr), 64'd0);
    chk("to_err_clr", 64'(irr.bus_err),   64'd0);
    chk("to_next",    64'(irr.itsyours),  64'h8);

    // Reset while master 3 is in XFER
    irr.request = 4'b0000;
    step();
    chk("ra_sel", 64'(irr.select_slave), 64'd1);
    step();
    #2 BusReset = 1'b0;
    #1;
    chk("ra_gnt",  64'(irr.itsyours),     64'd0);
    chk("ra_sel0", 64'(irr.select_slave), 64'd0);
    chk("ra_adr",  64'(irr.Adr),          64'd0);
    chk("ra_din",  64'(irr.dataIn),       64'd0);
    chk("ra_mdin", 64'(irr.Mdin),         64'd0);
    step();
    chk("ra_xm",  64'(irr.Xend_mstr), 64'd0);
    chk("ra_err", 64'(irr.bus_err),   64'd0);
    #2 BusReset = 1'b1;
    irr.request = 4'b1000;
    step();
    chk("rr3_gnt", 64'(irr.itsyours), 64'h8);
    step();
    irr.Xend     = 1'b1;
    irr.dbus_out = 16'h3333;
    step();
    chk("rr3_xm",   64'(irr.Xend_mstr), 64'h8);
    chk("rr3_mdin", 64'(irr.Mdin),      64'h3333);
    irr.request = 4'b1001;
    irr.Xend    = 1'b0;
    step();
    chk("rr_after3", 64'(irr.itsyours), 64'h1);

    // Request dropped during transfer, then stray Xend in IDLE
    step();
    irr.request = 4'b0000;
    step();
    chk("drop_gnt", 64'(irr.itsyours), 64'h1);
    irr.Xend     = 1'b1;
    irr.dbus_out = 16'h4343;
    step();
    chk("drop_xm",   64'(irr.Xend_mstr), 64'h1);
    chk("drop_err",  64'(irr.bus_err),   64'd0);
    chk("drop_mdin", 64'(irr.Mdin),      64'h4343);
    irr.dbus_out = 16'hDEAD;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("stray%0d_xm", k),   64'(irr.Xend_mstr),    64'd0);
      chk($sformatf("stray%0d_gnt", k),  64'(irr.itsyours),     64'd0);
      chk($sformatf("stray%0d_sel", k),  64'(irr.select_slave), 64'd0);
      chk($sformatf("stray%0d_mdin", k), 64'(irr.Mdin),         64'h4343);
    end
    irr.Xend = 1'b0;

    // Fixed priority: master 1 beats master 3 every time
    ifp.request  = 4'b1010;
    ifp.Xend     = 1'b1;
    ifp.dbus_out = 16'h0F0F;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("fp%0d_gnt", k), 64'(ifp.itsyours),  (k % 3 == 0) ? 64'd0 : 64'h2);
      chk($sformatf("fp%0d_xm", k),  64'(ifp.Xend_mstr), (k % 3 == 0) ? 64'h2 : 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
